anode_scanner: RTL and testbench

//   Parametrised N-digit anode scanner for multiplexed 7-segment displays.

---
 rtl/anode_scanner.sv | 108 ++++++++++
 tb/tb_anode_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anode_scanner.sv
// Multiplexed 7-segment anode scanner: prescaled one-hot digit walk
// with direction, per-digit blanking, dead-time and index load.
module anode_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 1,
    parameter int DEADTIME   = 0,
    parameter bit ACTIVE_LOW = 1,
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic                  load,
    input  logic [IW-1:0]         load_idx,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [IW-1:0]         digit_sel,
    output logic                  tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEADTIME);
    localparam logic [NUM_DIGITS-1:0] OFF =
        ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] RST_HOT =
        (DEADTIME == 0) ? NUM_DIGITS'(1) : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] RST_ANODE = RST_HOT ^ OFF;

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic [IW-1:0]         load_val;
    logic                  tick_next;
    logic                  dead_ok;
    logic                  slot_on;
    logic [NUM_DIGITS-1:0] hot;
    logic [NUM_DIGITS-1:0] anode_next;

    // Out-of-range load indices fold to digit 0; only possible
    // when the digit count is not a power of two.
    if ((1 << IW) == NUM_DIGITS) begin : g_load_full
        assign load_val = load_idx;
    end else begin : g_load_clip
        assign load_val = (load_idx > LAST_IDX) ? '0 : load_idx;
    end

    // Dead-time window covers the first DEADTIME counts of each slot.
    if (DEADTIME == 0) begin : g_no_dead
        assign dead_ok = 1'b1;
    end else begin : g_dead
        assign dead_ok = (cnt_next >= DEAD_C);
    end

    // Next prescaler count, digit index and advance pulse.
    always_comb begin
        cnt_next  = cnt;
        idx_next  = idx;
        tick_next = 1'b0;
        if (load) begin
            cnt_next = '0;
            idx_next = load_val;
        end else if (en) begin
            if (cnt == LAST_CNT) begin
                cnt_next  = '0;
                tick_next = 1'b1;
                if (dir) begin
                    idx_next = (idx == '0) ? LAST_IDX : idx - IW'(1);
                end else begin
                    idx_next = (idx == LAST_IDX) ? '0 : idx + IW'(1);
                end
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Decode the upcoming index so anode and digit_sel stay aligned.
    always_comb begin
        slot_on = en && dead_ok && !blank_mask[idx_next];
        hot     = '0;
        if (slot_on) begin
            hot[idx_next] = 1'b1;
        end
        anode_next = hot ^ OFF;
    end

    // State and output registers; reset lands on digit 0, slot start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            tick  <= 1'b0;
            anode <= RST_ANODE;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            tick  <= tick_next;
            anode <= anode_next;
        end
    end

    assign digit_sel = idx;

endmodule

// File: tb/tb_anode_scanner.sv
// Scoreboard bench for anode_scanner: three configurations driven
// together, per-cycle expectations queued and popped after each edge.
module tb_anode_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en, dir, load;
    logic [7:0] blank_mask;
    logic [2:0] load_idx, load_idx2;

    logic [7:0] anode0;
    logic [2:0] sel0;
    logic       tick0;
    logic [3:0] anode1;
    logic [1:0] sel1;
    logic       tick1;
    logic [5:0] anode2;
    logic [2:0] sel2;
    logic       tick2;

    always #5 clk = ~clk;

    anode_scanner #(
        .NUM_DIGITS(8), .PRESCALE(1), .DEADTIME(0), .ACTIVE_LOW(1)
    ) u0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir),
        .blank_mask(blank_mask), .load(load), .load_idx(load_idx),
        .anode(anode0), .digit_sel(sel0), .tick(tick0)
    );

    anode_scanner #(
        .NUM_DIGITS(4), .PRESCALE(4), .DEADTIME(1), .ACTIVE_LOW(1)
    ) u1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir),
        .blank_mask(4'b0000), .load(1'b0), .load_idx(2'b00),
        .anode(anode1), .digit_sel(sel1), .tick(tick1)
    );

    anode_scanner #(
        .NUM_DIGITS(6), .PRESCALE(1), .DEADTIME(0), .ACTIVE_LOW(1)
    ) u2 (
        .clk(clk), .rst(rst), .en(en), .dir(dir),
        .blank_mask(blank_mask[5:0]), .load(load), .load_idx(load_idx2),
        .anode(anode2), .digit_sel(sel2), .tick(tick2)
    );

    typedef struct {
        int          k;
        logic [15:0] anode;
        int          sel;
        logic        tick;
    } exp_t;

    exp_t  sbq[$];
    int    nchk = 0;
    int    nerr = 0;
    string phase = "init";

    int NN[3] = '{8, 4, 6};
    int PP[3] = '{1, 4, 1};
    int DD[3] = '{0, 1, 0};
    int m_idx[3];
    int m_cnt[3];

    logic [7:0] up_tab[8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF,
                              8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [7:0] dn_tab[8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic predict(input int k);
        int          n, lidx;
        logic        ld, tk, on;
        logic [15:0] msk, ones, a;
        n    = NN[k];
        ld   = (k == 1) ? 1'b0 : load;
        lidx = (k == 2) ? int'(load_idx2) : int'(load_idx);
        msk  = (k == 1) ? 16'h0 :
               (k == 2) ? {10'h0, blank_mask[5:0]} : {8'h0, blank_mask};
        tk   = 1'b0;
        if (ld) begin
            m_idx[k] = (lidx >= n) ? 0 : lidx;
            m_cnt[k] = 0;
        end else if (en) begin
            if (m_cnt[k] == PP[k] - 1) begin
                m_cnt[k] = 0;
                tk = 1'b1;
                if (dir) m_idx[k] = (m_idx[k] == 0) ? n - 1 : m_idx[k] - 1;
                else     m_idx[k] = (m_idx[k] == n - 1) ? 0 : m_idx[k] + 1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
        ones = (16'd1 << n) - 16'd1;
        on   = en && (m_cnt[k] >= DD[k]) && !msk[m_idx[k]];
        a    = on ? (~(16'd1 << m_idx[k]) & ones) : ones;
        sbq.push_back('{k: k, anode: a, sel: m_idx[k], tick: tk});
    endtask

    task automatic step();
        exp_t        e;
        logic [15:0] ga;
        int          gs;
        logic        gt;
        for (int k = 0; k < 3; k++) predict(k);
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.k)
                0: begin ga = {8'h0, anode0};  gs = int'(sel0); gt = tick0; end
                1: begin ga = {12'h0, anode1}; gs = int'(sel1); gt = tick1; end
                default: begin
                    ga = {10'h0, anode2}; gs = int'(sel2); gt = tick2;
                end
            endcase
            chk($sformatf("%s u%0d anode", phase, e.k), 32'(ga), 32'(e.anode));
            chk($sformatf("%s u%0d sel", phase, e.k), gs, e.sel);
            chk($sformatf("%s u%0d tick", phase, e.k), 32'(gt), 32'(e.tick));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " u0 anode"}, 32'(anode0), 32'h0FE);
        chk({tag, " u0 sel"}, 32'(sel0), 0);
        chk({tag, " u0 tick"}, 32'(tick0), 0);
        chk({tag, " u1 anode"}, 32'(anode1), 32'hF);
        chk({tag, " u1 sel"}, 32'(sel1), 0);
        chk({tag, " u2 anode"}, 32'(anode2), 32'h3E);
        chk({tag, " u2 sel"}, 32'(sel2), 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
        check_reset_vals({tag, " held"});
    endtask

    initial begin
        en = 1'b0; dir = 1'b0; load = 1'b0;
        blank_mask = 8'h00; load_idx = 3'd0; load_idx2 = 3'd0;
        mreset();
        #1 rst = 1'b1;
        #1 check_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        phase = "scan_up";
        en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c <= 8) chk($sformatf("up tab %0d", c), 32'(anode0),
                            32'(up_tab[c-1]));
            chk($sformatf("slot u1 anode %0d", c), 32'(anode1),
                (c % 4 == 0) ? 32'hF : 32'((~(4'd1 << ((c / 4) % 4))) & 4'hF));
            chk($sformatf("slot u1 sel %0d", c), 32'(sel1), (c / 4) % 4);
            chk($sformatf("slot u1 tick %0d", c), 32'(tick1),
                (c % 4 == 0) ? 1 : 0);
        end

        phase = "scan_down";
        pulse_reset("rst2");
        dir = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("down tab %0d", c), 32'(anode0), 32'(dn_tab[c]));
        end
        for (int c = 0; c < 3; c++) step();
        dir = 1'b0;
        for (int c = 0; c < 3; c++) step();

        phase = "blank";
        blank_mask = 8'h04;
        for (int c = 0; c < 10; c++) begin
            step();
            if (sel0 == 3'd2) chk("blank slot anode", 32'(anode0), 32'hFF);
        end
        blank_mask = 8'h00;

        phase = "load";
        en = 1'b0; load = 1'b1; load_idx = 3'd5; load_idx2 = 3'd7;
        step();
        chk("load sel", 32'(sel0), 5);
        chk("load anode off", 32'(anode0), 32'hFF);
        chk("load clip sel", 32'(sel2), 0);
        load_idx2 = 3'd5;
        step();
        load_idx2 = 3'd6;
        step();
        chk("load clip6 sel", 32'(sel2), 0);
        load = 1'b0; en = 1'b1;
        step();

        phase = "hold";
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("hold anode off", 32'(anode0), 32'hFF);
        end
        en = 1'b1;
        step();
        step();
        pulse_reset("rst_mid");
        phase = "after_rst";
        step();
        chk("after rst anode", 32'(anode0), 32'hFD);

        phase = "random";
        for (int c = 0; c < 200; c++) begin
            en         = ($urandom_range(0, 4) != 0);
            dir        = 1'($urandom_range(0, 1));
            load       = ($urandom_range(0, 7) == 0);
            load_idx   = 3'($urandom_range(0, 7));
            load_idx2  = 3'($urandom_range(0, 7));
            blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
